// File: rtl/png_chunk_parser.sv
// png_chunk_parser: PNG signature/chunk front end. Checks the 8-byte
// signature, walks the LEN/TYPE/DATA/CRC structure of each chunk, captures
// the IHDR width/height and forwards IDAT payload bytes downstream with zero
// latency. Completes on IEND; any fault parks the FSM in ERR with a code.
// Optional feature: define PNG_CRC_CHK_EN to build the per-chunk CRC-32 check.
module png_chunk_parser #(
   parameter int DIM_WD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              done_o,
   input  logic              val_i,
   output logic              rdy_o,
   input  logic [7:0]        dat_i,
   output logic [DIM_WD-1:0] cfg_w_o,
   output logic [DIM_WD-1:0] cfg_h_o,
   output logic              hdr_val_o,
   output logic              val_o,
   input  logic              rdy_i,
   output logic [7:0]        dat_o,
   output logic              end_o,
   output logic              err_o,
   output logic [2:0]        err_code_o
);

   localparam logic [63:0] SIG_BYTES = 64'h89504E470D0A1A0A;
   localparam logic [31:0] T_IHDR    = 32'h49484452;
   localparam logic [31:0] T_IDAT    = 32'h49444154;
   localparam logic [31:0] T_IEND    = 32'h49454E44;

   typedef enum logic [2:0] {IDLE, SIG, LEN, TYPE, DATA, CRC, DONE, ERR} state_t;

   state_t              state, nxt;
   logic [2:0]          bcnt;        // byte index inside SIG/LEN/TYPE/CRC
   logic [31:0]         len;         // chunk length, then down-counter in DATA
   logic [31:0]         typ;         // current chunk type
   logic [3:0]          didx;        // saturating byte index inside DATA (IHDR fields)
   logic                first_chk;   // no chunk has been parsed yet
   logic                hdr_val, end_q, done_q;
   logic [2:0]          err_code, code_nxt;
   logic [DIM_WD-1:0]   cfg_w, cfg_h;
   logic                acc, is_idat, is_ihdr, dim_bad, crc_ok;
   logic [31:0]         len_nxt, typ_nxt;
   logic [63:0]         sig_sh;

   assign acc      = val_i & rdy_o;
   assign len_nxt  = {len[23:0], dat_i};
   assign typ_nxt  = {typ[23:0], dat_i};
   assign is_idat  = (typ == T_IDAT);
   assign is_ihdr  = (typ == T_IHDR);
   assign sig_sh   = SIG_BYTES << {bcnt, 3'b000};
   assign dat_o    = dat_i;
   assign cfg_w_o  = cfg_w;
   assign cfg_h_o  = cfg_h;
   assign hdr_val_o  = hdr_val;
   assign end_o      = end_q;
   assign done_o     = done_q;
   assign err_code_o = err_code;
   assign err_o      = (err_code != 3'd0);

`ifdef PNG_CRC_CHK_EN
   logic [31:0] crc, crc_rx;

   // Reflected CRC-32 (0xEDB88320), one byte per call, bitwise unrolled.
   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   assign crc_ok = ({crc_rx[23:0], dat_i} == ~crc);

   // CRC accumulator over type+data bytes; received CRC shifts in big-endian.
   always_ff @(posedge clk) begin
      if (rst || start_i) begin
         crc    <= 32'hFFFFFFFF;
         crc_rx <= 32'h0;
      end else if (acc) begin
         case (state)
            LEN:     crc    <= 32'hFFFFFFFF;
            TYPE:    crc    <= crc_upd(crc, dat_i);
            DATA:    crc    <= crc_upd(crc, dat_i);
            CRC:     crc_rx <= {crc_rx[23:0], dat_i};
            default: ;
         endcase
      end
   end
`else
   assign crc_ok = 1'b1;
`endif

   // IHDR dimension byte sets a bit at or above DIM_WD: byte k of the 32-bit
   // big-endian field covers bits (3-k)*8 .. (3-k)*8+7.
   always_comb begin
      dim_bad = 1'b0;
      for (int b = 0; b < 8; b++)
         if (((3 - int'(didx[1:0])) * 8 + b >= DIM_WD) && dat_i[b])
            dim_bad = 1'b1;
   end

   // Next state, error code and handshake outputs.
   always_comb begin
      nxt      = state;
      code_nxt = err_code;
      rdy_o    = 1'b0;
      val_o    = 1'b0;
      case (state)
         IDLE, DONE: rdy_o = 1'b0;
         DATA: begin
            rdy_o = is_idat ? rdy_i : 1'b1;
            val_o = is_idat ? val_i : 1'b0;
         end
         default: rdy_o = 1'b1;
      endcase
      if (acc) begin
         case (state)
            SIG: begin
               if (dat_i != sig_sh[63:56]) begin
                  nxt = ERR; code_nxt = 3'd1;
               end else if (bcnt == 3'd7) nxt = LEN;
            end
            LEN: if (bcnt == 3'd3) begin
               if (len_nxt[31]) begin nxt = ERR; code_nxt = 3'd6; end
               else nxt = TYPE;
            end
            TYPE: if (bcnt == 3'd3) begin
               if ((first_chk && (typ_nxt != T_IHDR || len != 32'd13)) ||
                   (!first_chk && typ_nxt == T_IHDR)) begin
                  nxt = ERR; code_nxt = 3'd2;
               end else if (len == 32'd0) nxt = CRC;
               else nxt = DATA;
            end
            DATA: begin
               if (is_ihdr && !didx[3] && dim_bad) begin
                  nxt = ERR; code_nxt = 3'd3;
               end else if (len == 32'd1) nxt = CRC;
            end
            CRC: if (bcnt == 3'd3) begin
               if (!crc_ok) begin nxt = ERR; code_nxt = 3'd4; end
               else if (typ == T_IEND) nxt = DONE;
               else nxt = LEN;
            end
            default: ;
         endcase
      end
   end

   // State register and per-byte datapath; start_i overrides any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE; bcnt <= '0; len <= '0; typ <= '0; didx <= '0;
         first_chk <= 1'b1; hdr_val <= 1'b0; end_q <= 1'b0; done_q <= 1'b0;
         err_code <= '0; cfg_w <= '0; cfg_h <= '0;
      end else if (start_i) begin
         state <= SIG; bcnt <= '0; len <= '0; typ <= '0; didx <= '0;
         first_chk <= 1'b1; hdr_val <= 1'b0; end_q <= 1'b0; done_q <= 1'b0;
         err_code <= '0; cfg_w <= '0; cfg_h <= '0;
      end else begin
         end_q  <= 1'b0;
         done_q <= 1'b0;
         if (acc) begin
            state    <= nxt;
            err_code <= code_nxt;
            bcnt     <= (nxt != state) ? 3'd0 : bcnt + 3'd1;
            done_q   <= (nxt != state) && (nxt == DONE || nxt == ERR);
            case (state)
               LEN: len <= len_nxt;
               TYPE: begin
                  typ  <= typ_nxt;
                  didx <= '0;
                  if (bcnt == 3'd3) begin
                     first_chk <= 1'b0;
                     end_q     <= (typ_nxt == T_IEND) && (nxt != ERR);
                  end
               end
               DATA: begin
                  len <= len - 32'd1;
                  if (!didx[3] || didx != 4'hF) didx <= didx + 4'd1;
                  if (is_ihdr && didx < 4'd4)      cfg_w <= DIM_WD'({cfg_w, dat_i});
                  else if (is_ihdr && didx < 4'd8) cfg_h <= DIM_WD'({cfg_h, dat_i});
               end
               CRC: if (bcnt == 3'd3 && is_ihdr && nxt == LEN) hdr_val <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule
